// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch-flush squash and a saturating load-use stall counter.
module id_ex_hazard_stage #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [XLEN-1:0]  id_rdata1,
   input  logic [XLEN-1:0]  id_rdata2,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [8:0]       id_ctrl,
   input  logic             flush,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             ex_valid,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [XLEN-1:0]  ex_rdata1,
   output logic [XLEN-1:0]  ex_rdata2,
   output logic [XLEN-1:0]  ex_imm,
   output logic [8:0]       ex_ctrl,
   output logic [CNT_W-1:0] stall_count
);

   // ctrl = {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0], Jump}
   localparam int unsigned MEMREAD_BIT = 7;

   logic             r_valid;
   logic [4:0]       r_rs1;
   logic [4:0]       r_rs2;
   logic [4:0]       r_rd;
   logic [XLEN-1:0]  r_rdata1;
   logic [XLEN-1:0]  r_rdata2;
   logic [XLEN-1:0]  r_imm;
   logic [8:0]       r_ctrl;
   logic [CNT_W-1:0] r_count;

   logic w_rs1_match;
   logic w_rs2_match;
   logic w_hz;
   logic w_stall;

   always_comb begin
      w_rs1_match = id_uses_rs1 & (r_rd == id_rs1);
      w_rs2_match = id_uses_rs2 & (r_rd == id_rs2);
      w_hz        = r_valid & r_ctrl[MEMREAD_BIT] & (r_rd != 5'd0) & id_valid &
                    (w_rs1_match | w_rs2_match);
      // Gating with rst_n keeps PC/IF-ID writable during reset even before
      // the EX register has been cleared.
      w_stall     = w_hz & ~flush & rst_n;
   end

   assign pc_write    = ~w_stall;
   assign if_id_write = ~w_stall;

   always_ff @(posedge clk) begin
      if (!rst_n || flush || w_stall) begin
         r_valid  <= 1'b0;
         r_rs1    <= '0;
         r_rs2    <= '0;
         r_rd     <= '0;
         r_rdata1 <= '0;
         r_rdata2 <= '0;
         r_imm    <= '0;
         r_ctrl   <= '0;
      end else begin
         r_valid  <= id_valid;
         r_rs1    <= id_rs1;
         r_rs2    <= id_rs2;
         r_rd     <= id_rd;
         r_rdata1 <= id_rdata1;
         r_rdata2 <= id_rdata2;
         r_imm    <= id_imm;
         r_ctrl   <= id_valid ? id_ctrl : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_stall && (r_count != '1)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign ex_valid    = r_valid;
   assign ex_rs1      = r_rs1;
   assign ex_rs2      = r_rs2;
   assign ex_rd       = r_rd;
   assign ex_rdata1   = r_rdata1;
   assign ex_rdata2   = r_rdata2;
   assign ex_imm      = r_imm;
   assign ex_ctrl     = r_ctrl;
   assign stall_count = r_count;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Randomized self-checking bench for id_ex_hazard_stage against a
// behavioural model of the EX slot and the stall counter.
module tb_id_ex_hazard_stage;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned CNT_W = 4;
   localparam int          CMAX  = 15;

   localparam logic [8:0] C_LD   = 9'h1A8;  // RegWrite|MemRead|MemtoReg|ALUSrc
   localparam logic [8:0] C_ADD  = 9'h104;  // RegWrite|ALUOp=10
   localparam logic [8:0] C_ADDI = 9'h10C;  // RegWrite|ALUSrc|ALUOp=10

   logic             clk = 1'b0;
   logic             rst_n;
   logic             id_valid;
   logic [4:0]       id_rs1, id_rs2, id_rd;
   logic             id_uses_rs1, id_uses_rs2;
   logic [XLEN-1:0]  id_rdata1, id_rdata2, id_imm;
   logic [8:0]       id_ctrl;
   logic             flush;
   logic             pc_write, if_id_write, ex_valid;
   logic [4:0]       ex_rs1, ex_rs2, ex_rd;
   logic [XLEN-1:0]  ex_rdata1, ex_rdata2, ex_imm;
   logic [8:0]       ex_ctrl;
   logic [CNT_W-1:0] stall_count;

   int total = 0;
   int bad   = 0;

   // Model of what EX should hold: the previous accepted ID instruction.
   bit              m_valid;
   bit [4:0]        m_rs1, m_rs2, m_rd;
   bit [XLEN-1:0]   m_d1, m_d2, m_imm;
   bit [8:0]        m_ctrl;
   int              m_cnt;

   always #5 clk = ~clk;

   id_ex_hazard_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
      .id_ctrl(id_ctrl), .flush(flush),
      .pc_write(pc_write), .if_id_write(if_id_write), .ex_valid(ex_valid),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
      .ex_ctrl(ex_ctrl), .stall_count(stall_count)
   );

   // True when the instruction in EX is a real load whose destination is
   // a nonzero register that the ID instruction actually reads.
   function automatic bit model_stall();
      bit load_in_ex, reads_it;
      load_in_ex = m_valid && m_ctrl[7] && (m_rd != 0);
      reads_it   = (id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd);
      return rst_n && !flush && id_valid && load_in_ex && reads_it;
   endfunction

   task automatic model_clear();
      m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      m_d1 = 0; m_d2 = 0; m_imm = 0; m_ctrl = 0;
   endtask

   task automatic tick();
      bit s;
      s = model_stall();
      @(posedge clk);
      #1;
      if (!rst_n) begin
         model_clear();
         m_cnt = 0;
      end else begin
         if (flush || s) model_clear();
         else begin
            m_valid = id_valid; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_d1 = id_rdata1; m_d2 = id_rdata2; m_imm = id_imm;
            m_ctrl = id_valid ? id_ctrl : 9'd0;
         end
         if (s) m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
      end
   endtask

   task automatic drive(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit [4:0] rd, input bit u1, input bit u2,
                        input bit [8:0] ctrl);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_uses_rs1 = u1; id_uses_rs2 = u2; id_ctrl = ctrl;
      id_rdata1 = {$urandom(), $urandom()};
      id_rdata2 = {$urandom(), $urandom()};
      id_imm    = {$urandom(), $urandom()};
   endtask

   task automatic test_reset();
      rst_n = 0; flush = 0;
      for (int i = 0; i < 2; i++) begin
         drive(1, 5'($urandom()), 5'($urandom()), 5'($urandom()), 1, 1, C_LD);
         #1;
         total++;
         if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            bad++; $display("FAIL reset_pc_write got=%b/%b want=1/1", pc_write, if_id_write);
         end
         tick();
      end
      total++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || ex_rd !== 5'd0 || ex_rs1 !== 5'd0 ||
          ex_rs2 !== 5'd0 || ex_rdata1 !== '0 || ex_rdata2 !== '0 || ex_imm !== '0) begin
         bad++; $display("FAIL reset_regs got v=%b ctrl=%h rd=%0d rs1=%0d rs2=%0d want all 0",
                         ex_valid, ex_ctrl, ex_rd, ex_rs1, ex_rs2);
      end
      total++;
      if (stall_count !== 4'd0) begin
         bad++; $display("FAIL reset_count got=%0d want=0", stall_count);
      end
      total++;
      if (pc_write !== 1'b1) begin
         bad++; $display("FAIL reset_pc_after got=%b want=1", pc_write);
      end
      rst_n = 1;
   endtask

   task automatic test_load_use();
      drive(1, 5'd2, 5'd0, 5'd5, 1, 0, C_LD);       // ld x5, 0(x2)
      tick();
      drive(1, 5'd5, 5'd7, 5'd6, 1, 1, C_ADD);      // add x6, x5, x7
      #1;
      total++;
      if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin
         bad++; $display("FAIL lu_freeze got=%b/%b want=0/0", pc_write, if_id_write);
      end
      tick();
      total++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || ex_rd !== 5'd0 ||
          ex_rs1 !== 5'd0 || ex_rs2 !== 5'd0) begin
         bad++; $display("FAIL lu_bubble got v=%b ctrl=%h rd=%0d rs1=%0d rs2=%0d want 0",
                         ex_valid, ex_ctrl, ex_rd, ex_rs1, ex_rs2);
      end
      total++;
      if (stall_count !== 4'd1) begin
         bad++; $display("FAIL lu_count got=%0d want=1", stall_count);
      end
      total++;
      if (pc_write !== 1'b1) begin
         bad++; $display("FAIL lu_release got=%b want=1", pc_write);
      end
      tick();
      total++;
      if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_rs2 !== 5'd7 || ex_rd !== 5'd6 ||
          ex_ctrl !== C_ADD || ex_rdata1 !== id_rdata1) begin
         bad++; $display("FAIL lu_add got v=%b rs1=%0d rs2=%0d rd=%0d ctrl=%h want 1/5/7/6/%h",
                         ex_valid, ex_rs1, ex_rs2, ex_rd, ex_ctrl, C_ADD);
      end
   endtask

   task automatic test_non_hazard();
      drive(1, 5'd2, 5'd0, 5'd0, 1, 0, C_LD);       // ld x0
      tick();
      drive(1, 5'd0, 5'd0, 5'd6, 1, 1, C_ADD);      // add x6, x0, x0
      #1;
      total++;
      if (pc_write !== 1'b1) begin
         bad++; $display("FAIL x0_nostall got=%b want=1", pc_write);
      end
      tick();
      drive(1, 5'd2, 5'd0, 5'd5, 1, 0, C_LD);       // ld x5
      tick();
      drive(1, 5'd0, 5'd5, 5'd6, 1, 0, C_ADDI);     // addi x6, x0, 1 (rs2 field=5)
      #1;
      total++;
      if (pc_write !== 1'b1) begin
         bad++; $display("FAIL unused_rs2 got=%b want=1", pc_write);
      end
      tick();
      total++;
      if (ex_valid !== 1'b1 || ex_ctrl !== C_ADDI || stall_count !== 4'd1) begin
         bad++; $display("FAIL unused_rs2_ex got v=%b ctrl=%h cnt=%0d want 1/%h/1",
                         ex_valid, ex_ctrl, stall_count, C_ADDI);
      end
   endtask

   task automatic test_flush_hazard();
      drive(1, 5'd2, 5'd0, 5'd5, 1, 0, C_LD);
      tick();
      drive(1, 5'd5, 5'd7, 5'd6, 1, 1, C_ADD);
      flush = 1;
      #1;
      total++;
      if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
         bad++; $display("FAIL flush_pc got=%b/%b want=1/1", pc_write, if_id_write);
      end
      tick();
      flush = 0;
      total++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || stall_count !== 4'd1) begin
         bad++; $display("FAIL flush_ex got v=%b ctrl=%h cnt=%0d want 0/0/1",
                         ex_valid, ex_ctrl, stall_count);
      end
   endtask

   task automatic test_back_to_back();
      bit [XLEN-1:0] e1, e2, ei;
      for (int i = 0; i < 10; i++) begin
         drive(1, 5'(i + 1), 5'(i + 11), 5'(i + 21), 1, 1, C_ADD);
         id_rdata1 = (i % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
         id_rdata2 = ~id_rdata1;
         e1 = id_rdata1; e2 = id_rdata2; ei = id_imm;
         #1;
         total++;
         if (pc_write !== 1'b1) begin
            bad++; $display("FAIL b2b_pc[%0d] got=%b want=1", i, pc_write);
         end
         tick();
         total++;
         if (ex_valid !== 1'b1 || ex_rdata1 !== e1 || ex_rdata2 !== e2 || ex_imm !== ei ||
             ex_rs1 !== 5'(i + 1) || ex_rd !== 5'(i + 21) || ex_ctrl !== C_ADD) begin
            bad++; $display("FAIL b2b_ex[%0d] got d1=%h d2=%h imm=%h want %h %h %h",
                            i, ex_rdata1, ex_rdata2, ex_imm, e1, e2, ei);
         end
      end
      total++;
      if (stall_count !== 4'd1) begin
         bad++; $display("FAIL b2b_count got=%0d want=1", stall_count);
      end
   endtask

   task automatic test_saturation();
      int stalls;
      stalls = 0;
      // ld x5,0(x5) repeatedly: each copy hazards on the one ahead of it,
      // giving a stall every other cycle.
      drive(1, 5'd5, 5'd0, 5'd5, 1, 0, C_LD);
      for (int i = 0; i < 41; i++) begin
         #1;
         if (pc_write === 1'b0) stalls++;
         tick();
      end
      total++;
      if (stalls != 20) begin
         bad++; $display("FAIL sat_stalls got=%0d want=20", stalls);
      end
      total++;
      if (stall_count !== 4'd15) begin
         bad++; $display("FAIL sat_count got=%0d want=15", stall_count);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         rst_n = ($urandom_range(0, 39) != 0);
         flush = ($urandom_range(0, 7) == 0);
         drive($urandom_range(0, 5) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 1'($urandom()), 1'($urandom()),
               ($urandom_range(0, 1) == 1) ? C_LD : 9'($urandom()));
         #1;
         total++;
         if (pc_write !== !model_stall() || if_id_write !== !model_stall()) begin
            bad++; $display("FAIL rnd_pc[%0d] got=%b/%b want=%b", i, pc_write, if_id_write,
                            !model_stall());
         end
         tick();
         total++;
         if (ex_valid !== m_valid || ex_ctrl !== m_ctrl || ex_rd !== m_rd ||
             ex_rs1 !== m_rs1 || ex_rs2 !== m_rs2 || stall_count !== 4'(m_cnt)) begin
            bad++; $display("FAIL rnd_ex[%0d] got v=%b c=%h rd=%0d rs=%0d/%0d n=%0d want %b %h %0d %0d/%0d %0d",
                            i, ex_valid, ex_ctrl, ex_rd, ex_rs1, ex_rs2, stall_count,
                            m_valid, m_ctrl, m_rd, m_rs1, m_rs2, m_cnt);
         end
         if (m_valid) begin
            total++;
            if (ex_rdata1 !== m_d1 || ex_rdata2 !== m_d2 || ex_imm !== m_imm) begin
               bad++; $display("FAIL rnd_data[%0d] got %h %h %h want %h %h %h",
                               i, ex_rdata1, ex_rdata2, ex_imm, m_d1, m_d2, m_imm);
            end
         end
      end
      rst_n = 1; flush = 0;
   endtask

   initial begin
      model_clear();
      m_cnt = 0;
      test_reset();
      test_load_use();
      test_non_hazard();
      test_flush_hazard();
      test_back_to_back();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
